// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the operation push-button conditioner.
//   N_BTN        : number of op button channels (fixed at 4)
//   BTN_ADD..OR  : bit positions on the op bus, {or,and,sub,add}
//   lock_state_t : lockout FSM state encoding
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int N_BTN   = 4;

  localparam int BTN_ADD = 0;
  localparam int BTN_SUB = 1;
  localparam int BTN_AND = 2;
  localparam int BTN_OR  = 3;

  typedef enum logic {
    S_ARMED  = 1'b0,
    S_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/btn_op_cond_if.sv
// -----------------------------------------------------------------------------
// btn_op_cond_if
// Bundles the button-side and control-FSM-side signals of btn_op_cond.
//   btn_raw      : raw board buttons, {or,and,sub,add}
//   op_btn_pulse : one-hot single-cycle press pulse, {or,and,sub,add}
//   btn_level    : debounced stable level per button
//   locked       : high while the lockout is active
//   state        : lockout FSM state, exported for observation
// Modports:
//   master : the side that drives the buttons and consumes the pulses
//   slave  : the conditioner itself
// Handshake: there is no valid/ready pair. op_btn_pulse is a registered
// strobe; a nonzero value is valid for exactly one clock and the consumer
// must accept it in that cycle (it cannot apply backpressure).
// -----------------------------------------------------------------------------
interface btn_op_cond_if;
  import btn_pkg::*;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] op_btn_pulse;
  logic [N_BTN-1:0] btn_level;
  logic             locked;
  lock_state_t      state;

  modport master (
    output btn_raw,
    input  op_btn_pulse,
    input  btn_level,
    input  locked,
    input  state
  );

  modport slave (
    input  btn_raw,
    output op_btn_pulse,
    output btn_level,
    output locked,
    output state
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchroniser followed by a stability counter.
// A new level is accepted only after it has been seen for DB_CYCLES
// consecutive clocks; any return to the current stable level restarts the
// count from zero.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset (all flops and the count to 0)
//   btn_in : asynchronous raw button level (already polarity-corrected)
//   level  : debounced stable level (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        // Counting began on the first differing clock, so reaching
        // DB_CYCLES-1 here means DB_CYCLES consecutive differing samples.
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_op_cond.sv
// -----------------------------------------------------------------------------
// btn_op_cond
// Conditions the four operation buttons (add, sub, and, or) for the
// calculator control FSM: synchronise + debounce each channel, detect rising
// edges of the debounced level, pick the highest-priority edge (add > sub >
// and > or) and emit it as a registered one-hot pulse. After a pulse the block
// locks out further pulses until every button is released (debounced).
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : btn_op_cond_if.slave (btn_raw in; op_btn_pulse, btn_level,
//         locked, state out)
// Build option:
//   BTN_ACTIVE_LOW_EN : when defined, btn_raw is active-low on the pins and is
//                       inverted before the synchroniser. Internal levels
//                       still reset to "released" (0).
// -----------------------------------------------------------------------------
module btn_op_cond
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  btn_op_cond_if.slave bus
);

  logic [N_BTN-1:0] raw_eff;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] sel;
  logic [N_BTN-1:0] pulse_q;
  logic [N_BTN-1:0] pulse_d;
  lock_state_t      state_q;
  lock_state_t      state_d;

`ifdef BTN_ACTIVE_LOW_EN
  assign raw_eff = ~bus.btn_raw;
`else
  assign raw_eff = bus.btn_raw;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_in (raw_eff[i]),
      .level  (stable[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;

  // Isolate the lowest set bit: bit0 (add) is the highest priority.
  assign sel = rise & (~rise + N_BTN'(1));

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    case (state_q)
      S_ARMED: begin
        if (|rise) begin
          // Lower-priority simultaneous rises are dropped, not queued.
          pulse_d = sel;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        // Rises are ignored here; a button still held when this clears
        // produces no pulse because it has no fresh rising edge.
        if (stable == '0) begin
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ARMED;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.op_btn_pulse = pulse_q;
  assign bus.btn_level    = stable;
  assign bus.locked       = (state_q == S_LOCKED);
  assign bus.state        = state_q;

endmodule

// File: tb/tb_btn_op_cond.sv
// -----------------------------------------------------------------------------
// tb_btn_op_cond
// Directed bench for btn_op_cond with DB_CYCLES=8. Inputs change 1 time unit
// after a rising edge, so the next rising edge is the first sampling edge k.
// Counting step() calls from that point, step n leaves the bench just after
// edge k+n-1: debounced level changes after step 10 (edge k+9) and the pulse
// is visible after step 11 (edge k+10).
// -----------------------------------------------------------------------------
module tb_btn_op_cond;
  import btn_pkg::*;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  logic [N_BTN-1:0] last_pulse = '0;

  always #5 clk = ~clk;

  btn_op_cond_if bus ();

  btn_op_cond #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Logical press pattern; pins are inverted when the active-low build is used.
  task automatic set_raw(input logic [N_BTN-1:0] v);
`ifdef BTN_ACTIVE_LOW_EN
    bus.btn_raw = ~v;
`else
    bus.btn_raw = v;
`endif
  endtask

  // Pulse monitor on the falling edge: counts every pulse and checks one-hot.
  always @(negedge clk) begin
    if (bus.op_btn_pulse != '0) begin
      pulse_cnt++;
      last_pulse = bus.op_btn_pulse;
      chk("pulse_onehot", 32'($onehot(bus.op_btn_pulse)), 32'd1);
    end
  end

  initial begin
    rst = 1'b1;
    set_raw(4'b0000);
    steps(3);
    chk("rst_pulse",  32'(bus.op_btn_pulse), 32'h0);
    chk("rst_level",  32'(bus.btn_level),    32'h0);
    chk("rst_locked", 32'(bus.locked),       32'h0);
    chk("rst_state",  32'(bus.state),        32'(S_ARMED));
    rst = 1'b0;
    steps(2);

    // ---- Clean press of add, held 20 clocks ----
    set_raw(4'b0001);
    steps(9);
    chk("clean_level_early", 32'(bus.btn_level), 32'h0);
    step();
    chk("clean_level",        32'(bus.btn_level),    32'h1);
    chk("clean_pulse_early",  32'(bus.op_btn_pulse), 32'h0);
    step();
    chk("clean_pulse",        32'(bus.op_btn_pulse), 32'h1);
    chk("clean_locked",       32'(bus.locked),       32'h1);
    chk("clean_state",        32'(bus.state),        32'(S_LOCKED));
    step();
    chk("clean_pulse_off",    32'(bus.op_btn_pulse), 32'h0);
    exp_pulses++;
    steps(8);
    set_raw(4'b0000);
    steps(10);
    chk("clean_rel_level",    32'(bus.btn_level), 32'h0);
    chk("clean_rel_still_lk", 32'(bus.locked),    32'h1);
    step();
    chk("clean_unlocked",     32'(bus.locked),    32'h0);
    chk("clean_count",        pulse_cnt,          exp_pulses);
    chk("clean_last",         32'(last_pulse),    32'h1);

    // ---- Glitch on sub: 5 clocks high ----
    set_raw(4'b0010);
    steps(5);
    set_raw(4'b0000);
    steps(12);
    chk("glitch_level",  32'(bus.btn_level),          32'h0);
    chk("glitch_cnt",    32'(dut.g_ch[1].u_db.cnt),   32'h0);
    chk("glitch_count",  pulse_cnt,                   exp_pulses);
    chk("glitch_locked", 32'(bus.locked),             32'h0);

    // ---- Bouncy press on and: toggle every 3 clocks for 12, then hold ----
    set_raw(4'b0100); steps(3);
    set_raw(4'b0000); steps(3);
    set_raw(4'b0100); steps(3);
    set_raw(4'b0000); steps(3);
    set_raw(4'b0100);
    steps(10);
    chk("bouncy_level",       32'(bus.btn_level),    32'h4);
    chk("bouncy_pulse_early", 32'(bus.op_btn_pulse), 32'h0);
    chk("bouncy_count_early", pulse_cnt,             exp_pulses);
    step();
    chk("bouncy_pulse",       32'(bus.op_btn_pulse), 32'h4);
    exp_pulses++;
    step();
    set_raw(4'b0000);
    steps(12);
    chk("bouncy_count",       pulse_cnt,      exp_pulses);
    chk("bouncy_unlocked",    32'(bus.locked), 32'h0);

    // ---- Simultaneous sub + or ----
    set_raw(4'b1010);
    steps(11);
    chk("simul_pulse",     32'(bus.op_btn_pulse), 32'h2);
    exp_pulses++;
    step();
    chk("simul_pulse_off", 32'(bus.op_btn_pulse), 32'h0);
    set_raw(4'b1000);
    steps(12);
    chk("simul_or_held_level", 32'(bus.btn_level), 32'h8);
    chk("simul_or_held_lock",  32'(bus.locked),    32'h1);
    chk("simul_or_held_count", pulse_cnt,          exp_pulses);
    set_raw(4'b0000);
    steps(12);
    chk("simul_unlocked", 32'(bus.locked), 32'h0);
    set_raw(4'b1000);
    steps(11);
    chk("simul_or_repress", 32'(bus.op_btn_pulse), 32'h8);
    exp_pulses++;
    step();
    set_raw(4'b0000);
    steps(12);
    chk("simul_count", pulse_cnt, exp_pulses);

    // ---- Hold-over lockout: or pressed while add held ----
    set_raw(4'b0001);
    steps(11);
    chk("hold_add_pulse", 32'(bus.op_btn_pulse), 32'h1);
    exp_pulses++;
    set_raw(4'b1001);
    steps(12);
    set_raw(4'b1000);
    steps(12);
    chk("hold_or_level",  32'(bus.btn_level), 32'h8);
    chk("hold_locked",    32'(bus.locked),    32'h1);
    chk("hold_no_or",     pulse_cnt,          exp_pulses);
    set_raw(4'b0000);
    steps(12);
    chk("hold_unlocked",  32'(bus.locked),    32'h0);
    chk("hold_no_or2",    pulse_cnt,          exp_pulses);
    set_raw(4'b1000);
    steps(11);
    chk("hold_or_repress", 32'(bus.op_btn_pulse), 32'h8);
    exp_pulses++;
    step();
    set_raw(4'b0000);
    steps(12);

    // ---- Reset while add held and locked ----
    set_raw(4'b0001);
    steps(11);
    chk("rstmid_pulse",  32'(bus.op_btn_pulse), 32'h1);
    exp_pulses++;
    steps(3);
    chk("rstmid_locked", 32'(bus.locked), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_out_pulse",  32'(bus.op_btn_pulse), 32'h0);
    chk("rstmid_out_level",  32'(bus.btn_level),    32'h0);
    chk("rstmid_out_locked", 32'(bus.locked),       32'h0);
    chk("rstmid_out_state",  32'(bus.state),        32'(S_ARMED));
    steps(10);
    chk("rstmid_pulse_early", 32'(bus.op_btn_pulse), 32'h0);
    step();
    chk("rstmid_fresh_pulse", 32'(bus.op_btn_pulse), 32'h1);
    exp_pulses++;
    step();
    set_raw(4'b0000);
    steps(12);
    chk("final_count",    pulse_cnt,       exp_pulses);
    chk("final_unlocked", 32'(bus.locked), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
